// File: rtl/i2c_sda_pkg.sv
// i2c_sda_pkg
//   Shared types and widths for the I2C slave SDA output path.
//   sda_mode_t  : drive request from the slave controller FSM
//   sda_state_t : state of the SDA update sequencer
//   SDA_MODE_W / HOLD_CNT_W are also used by the slave controller.
package i2c_sda_pkg;

    localparam int SDA_MODE_W = 2;
    localparam int HOLD_CNT_W = 8;   // holds HOLD_CYCLES-1 for HOLD_CYCLES up to 255

    typedef enum logic [SDA_MODE_W-1:0] {
        SDA_IDLE = 2'b00,
        SDA_ACK  = 2'b01,
        SDA_NACK = 2'b10,
        SDA_TX   = 2'b11
    } sda_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_UPDATE
    } sda_state_t;

    // Counter preload for a given hold time; zero hold never uses the timer.
    function automatic logic [HOLD_CNT_W-1:0] hold_reload(input int hold);
        if (hold <= 0)
            return '0;
        return HOLD_CNT_W'(hold - 1);
    endfunction

endpackage

// File: rtl/sda_hold_timer.sv
// sda_hold_timer
//   Loadable down-counter timing the gap between an SCL falling edge and
//   the SDA update. A reload strobe restarts the count; decrement stops at 0.
//   clk        : system clock
//   rst        : synchronous active-high reset (count -> 0)
//   reload     : load reload_val (wins over dec)
//   dec        : decrement by one when non-zero
//   reload_val : value loaded on reload
//   zero       : count is zero
module sda_hold_timer
    import i2c_sda_pkg::*;
#(
    parameter int W = HOLD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reload,
    input  logic         dec,
    input  logic [W-1:0] reload_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (reload)
            count <= reload_val;
        else if (dec && !zero)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sda_sequencer.sv
// sda_sequencer
//   I2C slave SDA output driver. Serialises a DATA_WIDTH-bit word or drives
//   ACK / NACK / IDLE levels, changing SDA only HOLD_CYCLES clocks after each
//   SCL falling edge (sda_out moves HOLD_CYCLES+2 cycles after the strobe).
//   Optional feature macro: SDA_ARB_CHECK_EN (arbitration-loss detection).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     sda_mode  : 00 IDLE, 01 ACK, 10 NACK, 11 TX
//     scl_fall  : SCL falling-edge strobe
//     load      : capture tx_data (ignored while busy)
//     tx_data   : word to transmit
//     sda_in    : sampled bus level          (SDA_ARB_CHECK_EN only)
//     scl_rise  : SCL rising-edge strobe     (SDA_ARB_CHECK_EN only)
//     arb_lost  : sticky arbitration lost    (SDA_ARB_CHECK_EN only)
//     sda_out   : SDA drive level, 1 = release
//     busy      : word loaded and not fully shifted
//     tx_done   : one-cycle pulse when a word completes
module sda_sequencer
    import i2c_sda_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SDA_MODE_W-1:0] sda_mode,
    input  logic                  scl_fall,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef SDA_ARB_CHECK_EN
    input  logic                  sda_in,
    input  logic                  scl_rise,
    output logic                  arb_lost,
`endif
    output logic                  sda_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = hold_reload(HOLD_CYCLES);

    sda_state_t            state, state_nxt;
    sda_mode_t             mode;
    logic                  hold_load, hold_dec, hold_zero, do_update;
    logic [DATA_WIDTH-1:0] shreg, shreg_shifted;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  next_bit, load_ok;

    assign mode    = sda_mode_t'(sda_mode);
    assign load_ok = load && !busy;

    assign next_bit      = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
    assign shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    sda_hold_timer #(.W(HOLD_CNT_W)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .reload     (hold_load),
        .dec        (hold_dec),
        .reload_val (HOLD_RELOAD),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // A strobe seen in S_UPDATE starts a fresh hold just like in S_IDLE;
    // a strobe in S_HOLD only restarts the wait, so at most one update results.
    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        do_update = 1'b0;
        case (state)
            S_IDLE, S_UPDATE: begin
                do_update = (state == S_UPDATE);
                state_nxt = S_IDLE;
                if (scl_fall) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nxt = S_UPDATE;
                    end else begin
                        hold_load = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (scl_fall)
                    hold_load = 1'b1;
                else if (hold_zero)
                    state_nxt = S_UPDATE;
                else
                    hold_dec = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sda_out  <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
`ifdef SDA_ARB_CHECK_EN
            arb_lost <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;

            // The update acts on the state before any same-cycle load.
            if (do_update) begin
                case (mode)
                    SDA_ACK: sda_out <= 1'b0;
                    SDA_TX: begin
                        if (bit_cnt != '0) begin
                            sda_out <= next_bit;
                            shreg   <= shreg_shifted;
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end else begin
                            sda_out <= 1'b1;
                            if (busy) begin
                                tx_done <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: sda_out <= 1'b1;
                endcase
            end

            if (load_ok) begin
                shreg   <= tx_data;
                bit_cnt <= CNT_W'(DATA_WIDTH);
                busy    <= 1'b1;
`ifdef SDA_ARB_CHECK_EN
                arb_lost <= 1'b0;
`endif
            end

`ifdef SDA_ARB_CHECK_EN
            // We released the line but someone else holds it low: back off.
            // load_ok needs busy=0 and this needs busy=1, so they never collide.
            if (scl_rise && busy && mode == SDA_TX && sda_out && !sda_in) begin
                arb_lost <= 1'b1;
                busy     <= 1'b0;
                bit_cnt  <= '0;
                sda_out  <= 1'b1;
                tx_done  <= 1'b0;
            end
`endif
        end
    end

endmodule
